// File: rtl/ltpi_csr_avmm_arbiter.sv
// ltpi_csr_avmm_arbiter: round-robin share of one LTPI CSR Avalon-MM slave among N_MASTERS requesters with a hang watchdog
// Ports:
//   clk, reset_n                    clock and asynchronous active-low reset
//   m_address/m_read/m_write/
//   m_writedata/m_byteenable        packed per-master command inputs (master i at slice i)
//   m_waitrequest                   per-master accept (low = command taken this cycle)
//   m_readdata, m_readdatavalid     shared read data, one-hot return strobe
//   s_*                             CSR slave Avalon-MM port
//   timeout_err, timeout_cnt        sticky watchdog flag and saturating event count
//   err_clr                         synchronous clear of the watchdog status
module ltpi_csr_avmm_arbiter #(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int TIMEOUT_CYC = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [N_MASTERS*ADDR_W-1:0]     m_address,
  input  logic [N_MASTERS-1:0]            m_read,
  input  logic [N_MASTERS-1:0]            m_write,
  input  logic [N_MASTERS*DATA_W-1:0]     m_writedata,
  input  logic [N_MASTERS*(DATA_W/8)-1:0] m_byteenable,
  output logic [N_MASTERS-1:0]            m_waitrequest,
  output logic [DATA_W-1:0]               m_readdata,
  output logic [N_MASTERS-1:0]            m_readdatavalid,
  output logic [ADDR_W-1:0]               s_address,
  output logic                            s_read,
  output logic                            s_write,
  output logic [DATA_W-1:0]               s_writedata,
  output logic [DATA_W/8-1:0]             s_byteenable,
  input  logic                            s_waitrequest,
  input  logic [DATA_W-1:0]               s_readdata,
  input  logic                            s_readdatavalid,
  output logic                            timeout_err,
  output logic [7:0]                      timeout_cnt,
  input  logic                            err_clr
);
  localparam int BE_W = DATA_W / 8;
  localparam int GW = N_MASTERS > 1 ? $clog2(N_MASTERS) : 1;
  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, ERR_RESP} state_t;
  state_t state;
  logic [GW-1:0] grant, last_grant, pick, idx;
  logic kind_rd;
  logic [WW-1:0] wdog;
  logic [DATA_W-1:0] rd_hold;
  logic [N_MASTERS-1:0] req;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wd;
  logic [BE_W-1:0] sel_be;
  logic fire, fire_issue, fire_wait, rd_done, wd_event;
  assign req = m_read | m_write;
  // Walk from last_grant+1 downward in priority so the nearest requester after the last owner wins.
  always_comb begin
    pick = last_grant;
    idx = last_grant;
    for (int k = N_MASTERS; k >= 1; k--) begin
      idx = GW'((int'(last_grant) + k) % N_MASTERS);
      if (req[idx]) pick = idx;
    end
  end
  always_comb begin
    sel_addr = '0;
    sel_wd = '0;
    sel_be = '0;
    for (int i = 0; i < N_MASTERS; i++)
      if (grant == GW'(i)) begin
        sel_addr = m_address[i*ADDR_W +: ADDR_W];
        sel_wd = m_writedata[i*DATA_W +: DATA_W];
        sel_be = m_byteenable[i*BE_W +: BE_W];
      end
  end
  assign fire = wdog == WW'(TIMEOUT_CYC - 1);
  assign fire_issue = state == ISSUE && fire;
  assign rd_done = state == WAIT_RD && s_readdatavalid;
  // A reply arriving in the watchdog's final cycle is still delivered rather than discarded.
  assign fire_wait = state == WAIT_RD && fire && !s_readdatavalid;
  assign wd_event = fire_issue || fire_wait;
  assign s_read = state == ISSUE && !fire && kind_rd;
  assign s_write = state == ISSUE && !fire && !kind_rd;
  assign s_address = state == ISSUE ? sel_addr : '0;
  assign s_writedata = state == ISSUE ? sel_wd : '0;
  assign s_byteenable = state == ISSUE ? sel_be : '0;
  assign m_readdata = rd_done ? s_readdata : state == ERR_RESP ? ERR_DATA : rd_hold;
  always_comb begin
    m_waitrequest = '1;
    m_readdatavalid = '0;
    if (state == ISSUE) m_waitrequest[grant] = fire ? 1'b0 : s_waitrequest;
    if (rd_done || state == ERR_RESP) m_readdatavalid[grant] = 1'b1;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      grant <= '0;
      last_grant <= GW'(N_MASTERS - 1);
      kind_rd <= 1'b0;
      wdog <= '0;
      rd_hold <= '0;
      timeout_err <= 1'b0;
      timeout_cnt <= '0;
    end else begin
      if (state == ISSUE || state == WAIT_RD) wdog <= wdog + 1'b1;
      case (state)
        IDLE:
          if (|req) begin
            grant <= pick;
            kind_rd <= m_read[pick];
            wdog <= '0;
            state <= ISSUE;
          end
        ISSUE:
          if (fire || !s_waitrequest) begin
            last_grant <= grant;
            state <= fire ? (kind_rd ? ERR_RESP : IDLE) : (kind_rd ? WAIT_RD : IDLE);
          end
        WAIT_RD:
          if (s_readdatavalid) begin
            rd_hold <= s_readdata;
            state <= IDLE;
          end else if (fire) state <= ERR_RESP;
        default: begin
          rd_hold <= ERR_DATA;
          state <= IDLE;
        end
      endcase
      timeout_err <= wd_event ? 1'b1 : err_clr ? 1'b0 : timeout_err;
      timeout_cnt <= wd_event ? (err_clr ? 8'd1 : timeout_cnt + {7'd0, timeout_cnt != 8'hFF}) :
                     err_clr ? 8'd0 : timeout_cnt;
    end
endmodule

// File: tb/tb_ltpi_csr_avmm_arbiter.sv
// tb_ltpi_csr_avmm_arbiter: directed self-checking bench for ltpi_csr_avmm_arbiter
module tb_ltpi_csr_avmm_arbiter;
  localparam int TO = 20;
  logic clk = 1'b0;
  logic reset_n;
  logic [31:0] m_address;
  logic [1:0] m_read, m_write;
  logic [63:0] m_writedata;
  logic [7:0] m_byteenable;
  logic [1:0] m_waitrequest, m_readdatavalid;
  logic [31:0] m_readdata;
  logic [15:0] s_address;
  logic s_read, s_write;
  logic [31:0] s_writedata;
  logic [3:0] s_byteenable;
  logic s_waitrequest, s_readdatavalid;
  logic [31:0] s_readdata;
  logic timeout_err;
  logic [7:0] timeout_cnt;
  logic err_clr;
  int n_cmp = 0;
  int n_err = 0;
  ltpi_csr_avmm_arbiter #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .m_address(m_address), .m_read(m_read), .m_write(m_write),
    .m_writedata(m_writedata), .m_byteenable(m_byteenable),
    .m_waitrequest(m_waitrequest), .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
    .timeout_err(timeout_err), .timeout_cnt(timeout_cnt), .err_clr(err_clr)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    reset_n = 1'b0;
    m_address = '0; m_read = '0; m_write = '0; m_writedata = '0; m_byteenable = '0;
    s_waitrequest = 1'b0; s_readdata = '0; s_readdatavalid = 1'b0; err_clr = 1'b0;
    #3;
    chk("rst_wait", m_waitrequest, 2'b11);
    chk("rst_rdv", m_readdatavalid, 0);
    chk("rst_rdata", m_readdata, 0);
    chk("rst_srw", {s_read, s_write}, 0);
    chk("rst_saddr", s_address, 0);
    chk("rst_err", {timeout_err, timeout_cnt}, 0);
    tick; tick;
    reset_n = 1'b1;
    // single write from M0
    m_address[15:0] = 16'h0010; m_writedata[31:0] = 32'h1234_5678; m_byteenable[3:0] = 4'hF;
    m_write = 2'b01;
    #1;
    chk("t1_idle_wait", m_waitrequest, 2'b11);
    chk("t1_idle_swr", s_write, 0);
    tick; #1;
    chk("t1_swr", s_write, 1);
    chk("t1_srd", s_read, 0);
    chk("t1_saddr", s_address, 16'h0010);
    chk("t1_swd", s_writedata, 32'h1234_5678);
    chk("t1_sbe", s_byteenable, 4'hF);
    chk("t1_wait", m_waitrequest, 2'b10);
    tick; m_write = '0; #1;
    chk("t1_back_swr", s_write, 0);
    chk("t1_back_wait", m_waitrequest, 2'b11);
    // read from M1, reply three cycles after accept
    m_address[31:16] = 16'h0004; m_read = 2'b10;
    #1;
    tick; #1;
    chk("t2_srd", s_read, 1);
    chk("t2_saddr", s_address, 16'h0004);
    chk("t2_wait", m_waitrequest, 2'b01);
    tick; m_read = '0; #1;
    chk("t2_wr1_srd", s_read, 0);
    chk("t2_wr1_rdv", m_readdatavalid, 0);
    tick; #1;
    chk("t2_wr2_rdv", m_readdatavalid, 0);
    tick; s_readdatavalid = 1'b1; s_readdata = 32'hA5A5_0001; #1;
    chk("t2_rdv", m_readdatavalid, 2'b10);
    chk("t2_rdata", m_readdata, 32'hA5A5_0001);
    tick; s_readdatavalid = 1'b0; #1;
    chk("t2_rdv_off", m_readdatavalid, 0);
    chk("t2_rdata_hold", m_readdata, 32'hA5A5_0001);
    // fairness: both masters write continuously
    m_writedata = {32'h2222_0000, 32'h1111_0000};
    m_write = 2'b11;
    for (int i = 0; i < 8; i++) begin
      tick; #1;
      chk("t3_grant", m_waitrequest, i % 2 == 0 ? 2'b10 : 2'b01);
      chk("t3_swd", s_writedata, i % 2 == 0 ? 32'h1111_0000 : 32'h2222_0000);
      tick;
    end
    m_write = '0;
    // hung slave on an M0 read
    s_waitrequest = 1'b1; m_address[15:0] = 16'h0020; m_read = 2'b01;
    #1;
    tick; #1;
    chk("t4_srd", s_read, 1);
    chk("t4_wait_c1", m_waitrequest, 2'b11);
    repeat (TO - 2) tick;
    #1;
    chk("t4_wait_pre", m_waitrequest, 2'b11);
    tick; #1;
    chk("t4_wait_fire", m_waitrequest, 2'b10);
    chk("t4_srd_forced", s_read, 0);
    tick; m_read = '0; #1;
    chk("t4_err_rdv", m_readdatavalid, 2'b01);
    chk("t4_err_rdata", m_readdata, 32'hDEAD_BEEF);
    chk("t4_err_flag", timeout_err, 1);
    chk("t4_err_cnt", timeout_cnt, 1);
    tick; s_readdatavalid = 1'b1; s_readdata = 32'h5555_AAAA; #1;
    chk("t4_late_rdv", m_readdatavalid, 0);
    chk("t4_late_rdata", m_readdata, 32'hDEAD_BEEF);
    tick; s_readdatavalid = 1'b0;
    // saturation: 259 more timed-out writes
    for (int i = 0; i < 259; i++) begin
      m_write = 2'b01;
      repeat (TO) tick;
      m_write = '0;
      tick; #1;
      if (i == 252) chk("t5_cnt_254", timeout_cnt, 254);
    end
    chk("t5_cnt_sat", timeout_cnt, 255);
    chk("t5_flag", timeout_err, 1);
    err_clr = 1'b1;
    tick; err_clr = 1'b0; #1;
    chk("t5_clr_flag", timeout_err, 0);
    chk("t5_clr_cnt", timeout_cnt, 0);
    m_write = 2'b01;
    repeat (TO) tick;
    m_write = '0; err_clr = 1'b1; #1;
    chk("t5_both_fire", m_waitrequest, 2'b10);
    tick; err_clr = 1'b0; #1;
    chk("t5_both_flag", timeout_err, 1);
    chk("t5_both_cnt", timeout_cnt, 1);
    // reset while waiting for read data
    s_waitrequest = 1'b0; m_address[31:16] = 16'h0040; m_read = 2'b10;
    #1;
    tick; #1;
    chk("t6_srd", s_read, 1);
    tick; m_read = '0; #1;
    chk("t6_wr_srd", s_read, 0);
    reset_n = 1'b0; #1;
    chk("t6_rst_wait", m_waitrequest, 2'b11);
    chk("t6_rst_rdv", m_readdatavalid, 0);
    chk("t6_rst_rdata", m_readdata, 0);
    chk("t6_rst_srw", {s_read, s_write}, 0);
    chk("t6_rst_saddr", s_address, 0);
    chk("t6_rst_err", {timeout_err, timeout_cnt}, 0);
    tick;
    reset_n = 1'b1; m_address[31:16] = 16'h0044; m_read = 2'b10;
    #1;
    tick; #1;
    chk("t6_new_saddr", s_address, 16'h0044);
    chk("t6_new_wait", m_waitrequest, 2'b01);
    tick; m_read = '0; s_readdatavalid = 1'b1; s_readdata = 32'h0BAD_F00D; #1;
    chk("t6_new_rdv", m_readdatavalid, 2'b10);
    chk("t6_new_rdata", m_readdata, 32'h0BAD_F00D);
    tick; s_readdatavalid = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
